// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and helper functions for the DDS voice bank.
package dds_pkg;

    localparam logic [2:0] WAVE_SAW    = 3'd0;
    localparam logic [2:0] WAVE_SQUARE = 3'd1;
    localparam logic [2:0] WAVE_TRI    = 3'd2;
    localparam logic [2:0] WAVE_SINE   = 3'd3;
    localparam logic [2:0] WAVE_NOISE  = 3'd4;

    localparam logic [1:0] FIELD_TUNE  = 2'd0;
    localparam logic [1:0] FIELD_CTRL  = 2'd1;
    localparam logic [1:0] FIELD_PW    = 2'd2;
    localparam logic [1:0] FIELD_ATTEN = 2'd3;

    // Feedback taps for x^16+x^14+x^13+x^11, as a mask over state bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Points sit at odd multiples of pi/64 so a bit-inverted index mirrors exactly.
    function automatic logic [14:0] sineQuarter(input logic [3:0] idx);
        logic [14:0] v;
        case (idx)
            4'd0:    v = 15'd1608;
            4'd1:    v = 15'd4808;
            4'd2:    v = 15'd7962;
            4'd3:    v = 15'd11039;
            4'd4:    v = 15'd14010;
            4'd5:    v = 15'd16846;
            4'd6:    v = 15'd19519;
            4'd7:    v = 15'd22005;
            4'd8:    v = 15'd24279;
            4'd9:    v = 15'd26319;
            4'd10:   v = 15'd28105;
            4'd11:   v = 15'd29621;
            4'd12:   v = 15'd30852;
            4'd13:   v = 15'd31785;
            4'd14:   v = 15'd32412;
            default: v = 15'd32728;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dds_voice_bank_if.sv
// Config write port and sample output bundle of the DDS voice bank.
interface dds_voice_bank_if #(
    parameter int NUM_VOICES = 4,
    parameter int TUNE_W     = 16,
    parameter int OUT_W      = 16
);
    localparam int VS_W = $clog2(NUM_VOICES);

    logic              sample_tick;
    logic              cfg_we;
    logic [VS_W-1:0]   cfg_voice;
    logic [1:0]        cfg_field;
    logic [TUNE_W-1:0] cfg_data;
    logic [OUT_W-1:0]  sample_out;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output sample_tick, cfg_we, cfg_voice, cfg_field, cfg_data,
        input  sample_out, sample_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, cfg_we, cfg_voice, cfg_field, cfg_data,
        output sample_out, sample_valid, busy, overrun
    );
endinterface

// File: rtl/dds_sine_quarter.sv
// Combinational sine from a 16-point quarter-wave table, mirrored and inverted
// across the four quadrants; offset-binary output. Assumes 8 <= WAVE_W <= 16.
module dds_sine_quarter
    import dds_pkg::*;
#(
    parameter int WAVE_W = 12
) (
    input  logic [WAVE_W-1:0] p,
    output logic [WAVE_W-1:0] o_sine
);
    logic [1:0]        w_quad;
    logic [3:0]        w_idx;
    logic [14:0]       w_lutVal;
    logic [WAVE_W-2:0] w_amp;
    logic              w_unusedLowBits;

    assign w_quad   = p[WAVE_W-1 -: 2];
    assign w_idx    = w_quad[0] ? ~p[WAVE_W-3 -: 4] : p[WAVE_W-3 -: 4];
    assign w_lutVal = sineQuarter(w_idx);
    assign w_amp    = (WAVE_W-1)'(w_lutVal >> (16 - WAVE_W));
    assign o_sine   = w_quad[1] ? {1'b0, ~w_amp} : {1'b1, w_amp};

    assign w_unusedLowBits = ^p[WAVE_W-7:0];
endmodule

// File: rtl/dds_voice_bank.sv
// N-voice DDS engine: voices share one waveform datapath, one voice per cycle,
// and are summed into a saturating offset-binary mix once per frame.
module dds_voice_bank
    import dds_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int TUNE_W     = 16,
    parameter int WAVE_W     = 12,
    parameter int OUT_W      = 16
) (
    input  logic            sys_clk,
    input  logic            rst,
    dds_voice_bank_if.slave bus
);
    localparam int VS_W  = $clog2(NUM_VOICES);
    localparam int ACC_W = WAVE_W + VS_W;
    localparam int SHIFT = OUT_W - WAVE_W;
    localparam int MIX_W = ACC_W + SHIFT;
    localparam logic [WAVE_W-1:0] MIDSCALE = {1'b1, {(WAVE_W-1){1'b0}}};

    logic [TUNE_W-1:0] r_tune  [NUM_VOICES];
    logic [TUNE_W-1:0] r_phase [NUM_VOICES];
    logic [2:0]        r_sel   [NUM_VOICES];
    logic              r_en    [NUM_VOICES];
    logic [WAVE_W-1:0] r_pw    [NUM_VOICES];
    logic [2:0]        r_atten [NUM_VOICES];

    state_t                   r_state, w_stateNext;
    logic [VS_W-1:0]          r_voice;
    logic signed [ACC_W-1:0]  r_acc;
    logic [15:0]              r_lfsr;
    logic [OUT_W-1:0]         r_sampleOut;
    logic                     r_overrun;

    logic                     w_lastVoice, w_phaseStep, w_busy, w_valid;
    logic [WAVE_W-1:0]        w_p, w_sine, w_wave;
    logic signed [WAVE_W-1:0] w_signed, w_scaled, w_contrib;
    logic signed [ACC_W-1:0]  w_accSum;
    logic signed [MIX_W-1:0]  w_mixWide;
    logic                     w_fits;
    logic [OUT_W-1:0]         w_mixSat, w_sampleNext;

    assign w_lastVoice = (r_voice == VS_W'(NUM_VOICES - 1));
    assign w_phaseStep = (r_state == ST_RUN) && r_en[r_voice];
    assign w_p         = r_phase[r_voice][TUNE_W-1 -: WAVE_W];

    dds_sine_quarter #(.WAVE_W(WAVE_W)) u_sine (
        .p      (w_p),
        .o_sine (w_sine)
    );

    always_comb begin
        w_wave = MIDSCALE;
        case (r_sel[r_voice])
            WAVE_SAW:    w_wave = w_p;
            WAVE_SQUARE: w_wave = (w_p < r_pw[r_voice]) ? '1 : '0;
            WAVE_TRI:    w_wave = w_p[WAVE_W-1] ? ~{w_p[WAVE_W-2:0], 1'b0}
                                                :  {w_p[WAVE_W-2:0], 1'b0};
            WAVE_SINE:   w_wave = w_sine;
            WAVE_NOISE:  w_wave = r_lfsr[15 -: WAVE_W];
            default:     ;
        endcase
    end

    assign w_signed  = {~w_wave[WAVE_W-1], w_wave[WAVE_W-2:0]};
    assign w_scaled  = w_signed >>> r_atten[r_voice];
    assign w_contrib = r_en[r_voice] ? w_scaled : '0;
    assign w_accSum  = r_acc + {{VS_W{w_contrib[WAVE_W-1]}}, w_contrib};

    // Saturate when the bits above the output sign are not a pure sign extension.
    assign w_mixWide = MIX_W'(w_accSum) <<< SHIFT;
    assign w_fits    = (w_mixWide[MIX_W-1:OUT_W-1] == {(VS_W+1){w_mixWide[MIX_W-1]}});
    assign w_mixSat  = w_fits ? w_mixWide[OUT_W-1:0]
                     : (w_mixWide[MIX_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}});
    assign w_sampleNext = {~w_mixSat[OUT_W-1], w_mixSat[OUT_W-2:0]};

    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.sample_tick) w_stateNext = ST_RUN;
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_lastVoice) w_stateNext = ST_OUT;
            end
            ST_OUT: begin
                w_busy      = 1'b1;
                w_valid     = 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // The mix is registered on the last voice so it is already visible in OUT.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_voice     <= '0;
            r_acc       <= '0;
            r_lfsr      <= LFSR_SEED;
            r_sampleOut <= {1'b1, {(OUT_W-1){1'b0}}};
            r_overrun   <= 1'b0;
        end else begin
            if (bus.sample_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_voice <= '0;
                    r_acc   <= '0;
                end
                ST_RUN: begin
                    r_acc   <= w_accSum;
                    r_voice <= r_voice + VS_W'(1);
                    if (w_lastVoice) r_sampleOut <= w_sampleNext;
                end
                ST_OUT:  r_lfsr <= lfsrNext(r_lfsr);
                default: ;
            endcase
        end
    end

    // A phase clear written while that voice is processed wins over its step.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_tune[v]  <= '0;
                r_phase[v] <= '0;
                r_sel[v]   <= WAVE_SAW;
                r_en[v]    <= 1'b0;
                r_pw[v]    <= MIDSCALE;
                r_atten[v] <= '0;
            end
        end else begin
            if (w_phaseStep) r_phase[r_voice] <= r_phase[r_voice] + r_tune[r_voice];
            if (bus.cfg_we) begin
                case (bus.cfg_field)
                    FIELD_TUNE: r_tune[bus.cfg_voice] <= bus.cfg_data;
                    FIELD_CTRL: begin
                        r_sel[bus.cfg_voice] <= bus.cfg_data[2:0];
                        r_en[bus.cfg_voice]  <= bus.cfg_data[3];
                        if (bus.cfg_data[4]) r_phase[bus.cfg_voice] <= '0;
                    end
                    FIELD_PW:    r_pw[bus.cfg_voice]    <= bus.cfg_data[WAVE_W-1:0];
                    FIELD_ATTEN: r_atten[bus.cfg_voice] <= bus.cfg_data[2:0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.sample_out   = r_sampleOut;
    assign bus.sample_valid = w_valid;
    assign bus.busy         = w_busy;
    assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_dds_voice_bank.sv
// Directed self-checking bench for dds_voice_bank with hand-computed samples.
module tb_dds_voice_bank;
    import dds_pkg::*;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    dds_voice_bank_if #(.NUM_VOICES(4), .TUNE_W(16), .OUT_W(16)) bus ();

    dds_voice_bank #(
        .NUM_VOICES (4),
        .TUNE_W     (16),
        .WAVE_W     (12),
        .OUT_W      (16)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int voice, input logic [1:0] field,
                                 input logic [15:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_voice = 2'(voice);
        bus.cfg_field = field;
        bus.cfg_data  = data;
        @(negedge sys_clk);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
    endtask

    // Tick, then wait (bounded) for sample_valid; returns the sample and its latency.
    task automatic runFrame(output logic [15:0] sample, output int latency);
        bus.sample_tick = 1'b1;
        @(negedge sys_clk);
        bus.sample_tick = 1'b0;
        latency = 1;
        while (bus.sample_valid !== 1'b1 && latency < 20) begin
            @(negedge sys_clk);
            latency++;
        end
        sample = bus.sample_out;
        @(negedge sys_clk);
    endtask

    task automatic checkFrame(input string tag, input logic [15:0] expected);
        logic [15:0] s;
        int          lat;
        runFrame(s, lat);
        checkOutput({tag, "_lat"}, 16'(lat), 16'd5);
        checkOutput(tag, s, expected);
    endtask

    initial begin
        logic [15:0] s;
        int          lat;
        int          validCount;
        int          validAt;

        bus.sample_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_voice   = '0;
        bus.cfg_field   = '0;
        bus.cfg_data    = '0;

        $display("[TB] reset values");
        resetDut();
        checkOutput("rst_out",     bus.sample_out,           16'h8000);
        checkOutput("rst_valid",   16'(bus.sample_valid),    16'd0);
        checkOutput("rst_busy",    16'(bus.busy),            16'd0);
        checkOutput("rst_overrun", 16'(bus.overrun),         16'd0);

        $display("[TB] latency and saw ramp");
        applyStimulus(0, FIELD_TUNE, 16'h0100);
        applyStimulus(0, FIELD_CTRL, 16'h0008);
        bus.sample_tick = 1'b1;
        @(negedge sys_clk);
        bus.sample_tick = 1'b0;
        checkOutput("busy_t1",  16'(bus.busy),         16'd1);
        checkOutput("valid_t1", 16'(bus.sample_valid), 16'd0);
        repeat (3) @(negedge sys_clk);
        checkOutput("valid_t4", 16'(bus.sample_valid), 16'd0);
        checkOutput("out_t4",   bus.sample_out,        16'h8000);
        @(negedge sys_clk);
        checkOutput("valid_t5", 16'(bus.sample_valid), 16'd1);
        checkOutput("busy_t5",  16'(bus.busy),         16'd1);
        checkOutput("saw_0",    bus.sample_out,        16'h0000);
        @(negedge sys_clk);
        checkOutput("valid_t6", 16'(bus.sample_valid), 16'd0);
        checkOutput("busy_t6",  16'(bus.busy),         16'd0);
        repeat (4) @(negedge sys_clk);
        checkFrame("saw_1", 16'h0100);
        repeat (4) @(negedge sys_clk);
        checkFrame("saw_2", 16'h0200);

        $display("[TB] noise");
        resetDut();
        applyStimulus(0, FIELD_CTRL, 16'h000C);
        checkFrame("noise_0", 16'hACE0);
        checkFrame("noise_1", 16'h59C0);

        $display("[TB] saturation");
        resetDut();
        for (int v = 0; v < 4; v++) applyStimulus(v, FIELD_CTRL, 16'h0009);
        checkFrame("sat_pos", 16'hFFFF);
        for (int v = 0; v < 4; v++) applyStimulus(v, FIELD_CTRL, 16'h0001);
        checkFrame("all_off", 16'h8000);
        for (int v = 0; v < 4; v++) begin
            applyStimulus(v, FIELD_PW, 16'h0000);
            applyStimulus(v, FIELD_CTRL, 16'h0009);
        end
        checkFrame("sat_neg", 16'h0000);

        $display("[TB] attenuation");
        resetDut();
        applyStimulus(0, FIELD_CTRL, 16'h0009);
        applyStimulus(0, FIELD_ATTEN, 16'h0001);
        checkFrame("atten_1", 16'hBFF0);
        applyStimulus(0, FIELD_ATTEN, 16'h0007);
        checkFrame("atten_7", 16'h80F0);

        $display("[TB] triangle");
        resetDut();
        applyStimulus(0, FIELD_TUNE, 16'h4000);
        applyStimulus(0, FIELD_CTRL, 16'h000A);
        checkFrame("tri_0", 16'h0000);
        checkFrame("tri_1", 16'h8000);
        checkFrame("tri_2", 16'hFFF0);
        checkFrame("tri_3", 16'h7FF0);

        $display("[TB] sine quadrants");
        resetDut();
        applyStimulus(0, FIELD_TUNE, 16'h4000);
        applyStimulus(0, FIELD_CTRL, 16'h000B);
        runFrame(s, lat);
        checkOutput("sine_q0", 16'((s >= 16'h8000) && (s < 16'h8800)), 16'd1);
        runFrame(s, lat);
        checkOutput("sine_q1", 16'(s >= 16'hF800), 16'd1);
        runFrame(s, lat);
        checkOutput("sine_q2", 16'((s < 16'h8000) && (s > 16'h7800)), 16'd1);
        runFrame(s, lat);
        checkOutput("sine_q3", 16'(s <= 16'h0800), 16'd1);

        $display("[TB] reserved select is midscale");
        resetDut();
        applyStimulus(0, FIELD_CTRL, 16'h000F);
        applyStimulus(1, FIELD_CTRL, 16'h0009);
        applyStimulus(1, FIELD_ATTEN, 16'h0007);
        checkFrame("midscale", 16'h80F0);

        $display("[TB] phase clear and wrap");
        resetDut();
        applyStimulus(0, FIELD_TUNE, 16'hFFFF);
        applyStimulus(0, FIELD_CTRL, 16'h0008);
        checkFrame("ph_a", 16'h0000);
        checkFrame("ph_b", 16'hFFF0);
        applyStimulus(0, FIELD_PW, 16'h0000);
        applyStimulus(0, FIELD_CTRL, 16'h0019);
        checkFrame("ph_clr_sq", 16'h0000);
        applyStimulus(0, FIELD_CTRL, 16'h0008);
        checkFrame("ph_d", 16'hFFF0);
        applyStimulus(0, FIELD_TUNE, 16'h0011);
        checkFrame("ph_e", 16'hFFF0);
        checkFrame("ph_wrap", 16'h0000);
        applyStimulus(0, FIELD_CTRL, 16'h0018);
        checkFrame("ph_clr_saw", 16'h0000);

        $display("[TB] overrun");
        resetDut();
        validCount = 0;
        validAt    = 0;
        bus.sample_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge sys_clk);
            bus.sample_tick = (k == 2);
            if (bus.sample_valid === 1'b1) begin
                validCount++;
                validAt = k;
            end
        end
        checkOutput("ovr_valid_count", 16'(validCount), 16'd1);
        checkOutput("ovr_valid_at",    16'(validAt),    16'd5);
        checkOutput("ovr_flag",        16'(bus.overrun), 16'd1);
        checkFrame("ovr_next_frame", 16'h8000);
        checkOutput("ovr_sticky",      16'(bus.overrun), 16'd1);
        resetDut();
        checkOutput("ovr_cleared",     16'(bus.overrun), 16'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, FIELD_TUNE, 16'h1000);
        applyStimulus(0, FIELD_CTRL, 16'h0008);
        checkFrame("pre_abort", 16'h0000);
        validCount = 0;
        bus.sample_tick = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sys_clk);
            bus.sample_tick = 1'b0;
            if (bus.sample_valid === 1'b1) validCount++;
            rst = (k == 2);
        end
        checkOutput("abort_valid", 16'(validCount), 16'd0);
        checkOutput("abort_busy",  16'(bus.busy),   16'd0);
        checkOutput("abort_out",   bus.sample_out,  16'h8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dds_voice_bank.md
# dds_voice_bank

Parametrised N-voice DDS engine, the successor to the fixed two-oscillator core. It processes all voices time-multiplexed through one shared waveform datapath, once per frame. Per-voice waveform, pulse width and attenuation are runtime-configurable, and a saturating mixer combines the voices into one offset-binary sample. It sits between the SPI command decoder (config write port) and the DAC serializer (`sample_out`/`sample_valid`).

## Interface
- `NUM_VOICES`, 4: number of voices, ≥2.
- `TUNE_W`, 16: tuning word and phase accumulator width.
- `WAVE_W`, 12: waveform sample width; `WAVE_W` ≤ `TUNE_W`.
- `OUT_W`, 16: output sample width; `OUT_W` ≥ `WAVE_W`.
- `VS_W`, derived as clog2(`NUM_VOICES`): voice index width.

Ports:
- `sys_clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_tick` in 1: single-cycle pulse that starts a frame.
- `cfg_we` in 1: config write strobe.
- `cfg_voice` in `VS_W`: target voice.
- `cfg_field` in 2: 0 = tune, 1 = control, 2 = pulse width, 3 = attenuation.
- `cfg_data` in `TUNE_W`: write data.
- `sample_out` out `OUT_W`: mixed sample, offset binary.
- `sample_valid` out 1: one-cycle pulse when `sample_out` updates.
- `busy` out 1: high while a frame is in progress.
- `overrun` out 1: sticky flag, cleared only by `rst`.

## Operation
**Config fields**
- Field 0: tune = `cfg_data`.
- Field 1: `sel` = `cfg_data[2:0]`, `en` = `cfg_data[3]`. `cfg_data[4]`=1 clears that voice's phase to 0.
- Field 2: pulse width = `cfg_data[WAVE_W-1:0]`.
- Field 3: attenuation = `cfg_data[2:0]`.
- Writes go to live registers in any state.
- A voice uses the register values present in the cycle it is processed.
- A write to a voice in the same cycle that voice is processed takes effect next frame.

**FSM**
- IDLE: on `sample_tick`, go to RUN with voice counter = 0.
- RUN: process voice `v` each cycle. After `NUM_VOICES-1`, go to OUT.
- OUT: latch the saturated mix, pulse `sample_valid`, return to IDLE.

**Per-voice waveform**
- Let `p` = top `WAVE_W` bits of the phase.
- `sel` 0, saw: `p`.
- `sel` 1, square: all-ones if `p` < pw, else 0.
- `sel` 2, triangle: `{p[WAVE_W-2:0],0}`, bitwise-inverted when `p` MSB = 1.
- `sel` 3, sine: quarter-wave LUT.
- `sel` 4, noise: top `WAVE_W` bits of the shared 16-bit LFSR.
- `sel` 5–7: midscale.
- Convert to signed by inverting the MSB, then arithmetic right-shift by the attenuation.

**Mixing and phase update**
- Enabled voices add into an accumulator of `WAVE_W+VS_W` bits. Disabled voices add 0 and their phase is frozen.
- An enabled voice's phase += tune, modulo 2^`TUNE_W`, after its sample is taken.
- The LFSR (x^16+x^14+x^13+x^11) advances once per frame, in OUT.

**Output**
- mix = accumulator <<< (`OUT_W-WAVE_W`), saturated to signed `OUT_W`.
- `sample_out` = mix with the MSB inverted.

**Boundary conditions**
- `sample_tick` in RUN or OUT: ignored, `overrun` set, the frame completes normally.
- `rst` mid-frame: frame aborted, no `sample_valid`.

## Timing
- Tick sampled in cycle t: voices processed in cycles t+1 … t+`NUM_VOICES`.
- `sample_valid` and the new `sample_out` appear in cycle t+`NUM_VOICES`+1.
- `busy` is high from t+1 through the OUT cycle.
- Minimum tick period is `NUM_VOICES`+2 cycles.
- Reset values:
  - All phases and tunes 0.
  - `sel` = 0, `en` = 0, pw = 2^(`WAVE_W`-1), attenuation 0.
  - LFSR = 16'hACE1.
  - `sample_out` = 2^(`OUT_W`-1).
  - `sample_valid`, `busy`, `overrun` = 0.

## Structure
- Package `dds_pkg` holds:
  - wave-select constants (SAW, SQUARE, TRI, SINE, NOISE);
  - cfg field codes;
  - the LFSR seed and taps;
  - the FSM state enum.
- Sub-module `dds_sine_quarter`: combinational quarter-wave sine. Input `p`, output `WAVE_W` offset-binary; it handles quadrant mirroring and inversion internally.
- Register file: per-voice arrays indexed by the voice counter.

## Test plan
All scenarios use `NUM_VOICES`=4, `WAVE_W`=12, `OUT_W`=16.
- **Latency:** after reset, voice 0 saw, en=1, tune 0x0100, ticks every 10 cycles → first `sample_out` 0x0000 at tick+5, then 0x0100, 0x0200.
- **Saturation:** all voices square, pw 0x800, en=1, tune 0 → `sample_out` 0xFFFF. Disable all voices → 0x8000.
- **Attenuation:** voice 0 only, square high, attenuation 1 → 0xBFF0. Attenuation 7 → 0x80F0.
- **Overrun:** ticks at t and t+2 → one `sample_valid` at t+5, `overrun`=1 held until `rst`.
- **Phase clear:** tune 0xFFFF saw, then a control write with `cfg_data`=0x19 → next sample 0x0000. Check wrap at 0xFFFF+0xFFFF → phase 0xFFFE.
- **Reset mid-frame:** `rst` at t+2 → no `sample_valid`, `busy`=0, `sample_out`=0x8000.
